// File: rtl/frame_shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_shift_ctrl_pkg
// Shared definitions for the frame shift controller and its delay line:
//   - state_e        : controller state encoding (IDLE, FILL, DRAIN)
//   - DEFAULT_*      : default frame length (words) and word width (bits)
//   - occ_width()    : number of bits needed to count 0..depth words
// -----------------------------------------------------------------------------
package frame_shift_ctrl_pkg;

  // Controller states. IDLE waits for enable, FILL accepts a frame,
  // DRAIN hands the frame downstream in arrival order.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_REGISTER_COUNT = 32'd21;
  localparam int unsigned DEFAULT_WIDTH          = 32'd8;

  // Width of a counter that must represent every value from 0 to depth
  // inclusive (a full line is a legal occupancy).
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/frame_shift_ctrl_word_delay_line.sv
// -----------------------------------------------------------------------------
// word_delay_line
// Fixed-depth shift register of words. On shift, word_in enters stage 0 and
// every stage moves one place towards the tail; word_out is the tail stage,
// i.e. the oldest word in the line.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, zeroes every stage
//   clear    in   synchronous clear, zeroes every stage
//   shift    in   advance the line by one stage
//   word_in  in   WIDTH  word entering the head
//   word_out out  WIDTH  oldest stage (tail)
// -----------------------------------------------------------------------------
module word_delay_line
  import frame_shift_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_REGISTER_COUNT,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] word_in,
  output logic [WIDTH-1:0] word_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Stage registers: reset and clear both wipe the whole line so that no
  // stale word can ever surface in a later frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (shift) begin
      stage_q[0] <= word_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign word_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_shift_ctrl.sv
// -----------------------------------------------------------------------------
// frame_shift_ctrl
// Collects a frame of REGISTER_COUNT words into a delay line, then drains the
// frame downstream in the same order, pulsing frame_done after the last word
// has been accepted. A full frame always occupies the whole line, so the tail
// of the line is the oldest word throughout the drain.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset (priority over flush)
//   enable      in   permits IDLE->FILL and the back-to-back next frame
//   flush       in   synchronous abort: clears state, count and line
//   in_valid    in   input word valid
//   in_data     in   WIDTH input word
//   in_ready    out  block accepts input (FILL and no flush)
//   out_valid   out  output word valid (DRAIN and no flush)
//   out_data    out  WIDTH oldest stored word, zero when out_valid=0
//   out_ready   in   downstream accepts output
//   busy        out  state is not IDLE
//   frame_done  out  one-cycle pulse after the last word of a frame drains
//   occupancy   out  words currently held
// -----------------------------------------------------------------------------
module frame_shift_ctrl
  import frame_shift_ctrl_pkg::*;
#(
  parameter int unsigned REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
  parameter int unsigned WIDTH          = DEFAULT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                flush,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    out_data,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                frame_done,
  output logic [occ_width(REGISTER_COUNT)-1:0] occupancy
);

  localparam int unsigned OCC_W = occ_width(REGISTER_COUNT);

  // Occupancy values the controller reacts to.
  localparam logic [OCC_W-1:0] OCC_ONE       = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_LAST_FILL = OCC_W'(REGISTER_COUNT - 32'd1);

  state_e           state_q;
  state_e           state_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             frame_done_q;
  logic             frame_done_d;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_in_s;
  logic             accept_out_s;
  logic             shift_s;
  logic [WIDTH-1:0] line_in_s;
  logic [WIDTH-1:0] line_out_s;

  // Handshake qualifiers. flush masks both directions combinationally so
  // that nothing is counted or shifted in the cycle being aborted.
  assign in_ready_s   = (state_q == ST_FILL)  && !flush;
  assign out_valid_s  = (state_q == ST_DRAIN) && !flush;
  assign accept_in_s  = in_valid  && in_ready_s;
  assign accept_out_s = out_valid_s && out_ready;

  // Delay-line drive: every accepted handshake advances the line; during the
  // drain zeros are pushed in behind the departing frame.
  assign shift_s   = accept_in_s || accept_out_s;
  assign line_in_s = (state_q == ST_FILL) ? in_data : {WIDTH{1'b0}};

  word_delay_line #(
    .DEPTH (REGISTER_COUNT),
    .WIDTH (WIDTH)
  ) u_line (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .shift    (shift_s),
    .word_in  (line_in_s),
    .word_out (line_out_s)
  );

  // Next-state, occupancy and frame-end decode.
  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    frame_done_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      occ_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (accept_in_s) begin
            // The accept that completes the frame moves straight to DRAIN,
            // so the first word is offered on the very next cycle.
            if (occ_q >= OCC_LAST_FILL) begin
              occ_d   = OCC_W'(REGISTER_COUNT);
              state_d = ST_DRAIN;
            end else begin
              occ_d   = occ_q + OCC_ONE;
              state_d = ST_FILL;
            end
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_DRAIN: begin
          if (accept_out_s) begin
            // enable is consulted here, at the frame boundary, and nowhere
            // else mid-frame.
            if (occ_q <= OCC_ONE) begin
              occ_d        = '0;
              frame_done_d = 1'b1;
              if (enable) begin
                state_d = ST_FILL;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              occ_d   = occ_q - OCC_ONE;
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          occ_d   = '0;
        end
      endcase
    end
  end

  // Controller state register; reset discards any frame in progress
  // without a frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      occ_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = out_valid_s ? line_out_s : {WIDTH{1'b0}};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_frame_shift_ctrl.sv
module tb_frame_shift_ctrl;

  localparam int N  = 21;
  localparam int W  = 8;
  localparam int OW = $clog2(N + 1);

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic [OW-1:0] occupancy;

  frame_shift_ctrl #(.REGISTER_COUNT(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int n_total   = 0;
  int n_pass    = 0;
  int cycle_no  = 0;
  int done_seen = 0;

  // Behavioural model: a frame is a queue of words; the mode says whether
  // the frame is being collected or handed out.
  int           m_mode = M_IDLE;
  logic [W-1:0] m_q[$];
  logic         m_done = 1'b0;

  // Values sampled from the DUT in the current cycle.
  logic          s_in_ready, s_out_valid, s_busy, s_frame_done;
  logic [W-1:0]  s_out_data;
  logic [OW-1:0] s_occupancy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle_no, act, exp);
  endtask

  task automatic compare_outputs();
    logic         e_ir, e_ov;
    logic [W-1:0] e_od;
    e_ir = (m_mode == M_FILL)  && !flush;
    e_ov = (m_mode == M_DRAIN) && !flush;
    e_od = (e_ov && m_q.size() > 0) ? m_q[0] : '0;
    s_in_ready   = in_ready;
    s_out_valid  = out_valid;
    s_out_data   = out_data;
    s_busy       = busy;
    s_frame_done = frame_done;
    s_occupancy  = occupancy;
    check("in_ready",   32'(s_in_ready),   32'(e_ir));
    check("out_valid",  32'(s_out_valid),  32'(e_ov));
    check("out_data",   32'(s_out_data),   32'(e_od));
    check("busy",       32'(s_busy),       32'(m_mode != M_IDLE));
    check("frame_done", 32'(s_frame_done), 32'(m_done));
    check("occupancy",  32'(s_occupancy),  32'(m_q.size()));
    if (s_frame_done === 1'b1) done_seen++;
  endtask

  task automatic model_update(input logic rst, input logic fl, input logic en,
                              input logic iv, input logic [W-1:0] id, input logic ordy);
    if (rst || fl) begin
      m_mode = M_IDLE;
      m_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_FILL;
        M_FILL: begin
          if (iv) begin
            m_q.push_back(id);
            if (m_q.size() == N) m_mode = M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (ordy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
              m_done = 1'b1;
              m_mode = en ? M_FILL : M_IDLE;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic cyc(input logic en, input logic fl, input logic iv,
                     input logic [W-1:0] id, input logic ordy, input logic rst);
    enable = en; flush = fl; in_valid = iv; in_data = id; out_ready = ordy; reset = rst;
    #3;
    compare_outputs();
    @(posedge clk);
    model_update(rst, fl, en, iv, id, ordy);
    cycle_no++;
    #1;
  endtask

  logic [W-1:0] words[$];
  int           accepted, got, d0;
  logic         iv_r, ordy_r;
  logic [W-1:0] d_r;

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, pinned with literals
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst busy", 32'(s_busy), 32'd0);
    check("rst occupancy", 32'(s_occupancy), 32'd0);
    check("rst in_ready", 32'(s_in_ready), 32'd0);
    check("rst out_data", 32'(s_out_data), 32'd0);

    // Basic frame: 0x01..0x15 back to back
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (i == 0) check("basic in_ready", 32'(s_in_ready), 32'd1);
    end
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 0) check("basic full occupancy", 32'(s_occupancy), 32'd21);
      check("basic drain data", 32'(s_out_data), 32'(i + 1));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("basic frame_done", 32'(s_frame_done), 32'd1);
    check("basic next FILL", 32'(s_in_ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("basic done count", 32'(done_seen - d0), 32'd1);

    // Random input gaps, then backpressured drain with enable low
    words.delete();
    accepted = 0;
    for (int t = 0; t < 600 && accepted < N; t++) begin
      iv_r = ($urandom_range(0, 2) != 0);
      d_r  = W'($urandom);
      cyc(1'b1, 1'b0, iv_r, d_r, 1'b1, 1'b0);
      if (iv_r && s_in_ready) begin
        words.push_back(d_r);
        accepted++;
      end
    end
    check("gap fill accepted", 32'(accepted), 32'(N));
    got = 0;
    for (int t = 0; t < 200 && got < N; t++) begin
      ordy_r = t[0];
      cyc(1'b0, 1'b0, 1'b0, 8'h00, ordy_r, 1'b0);
      if (s_out_valid && ordy_r) begin
        check("bp order", 32'(s_out_data), 32'(words[got]));
        got++;
      end
    end
    check("bp drained", 32'(got), 32'(N));
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("en-low frame_done", 32'(s_frame_done), 32'd1);
    check("en-low busy", 32'(s_busy), 32'd0);
    for (int t = 0; t < 3; t++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
      check("en-low in_ready", 32'(s_in_ready), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("re-enable in_ready", 32'(s_in_ready), 32'd1);

    // Flush after 10 accepted words
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
    d0 = done_seen;
    cyc(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    check("flush in_ready", 32'(s_in_ready), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("flush busy", 32'(s_busy), 32'd0);
    check("flush occupancy", 32'(s_occupancy), 32'd0);
    check("flush out_data", 32'(s_out_data), 32'd0);
    check("flush no done", 32'(s_frame_done), 32'd0);
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("post-flush data", 32'(s_out_data), 32'(8'h30 + i));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post-flush done count", 32'(done_seen - d0), 32'd1);

    // Reset mid-DRAIN with occupancy 7
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    for (int i = 0; i < N - 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("pre-reset occupancy", 32'(s_occupancy), 32'd7);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("reset occupancy", 32'(s_occupancy), 32'd0);
    check("reset busy", 32'(s_busy), 32'd0);
    check("reset out_valid", 32'(s_out_valid), 32'd0);
    check("reset out_data", 32'(s_out_data), 32'd0);
    check("reset no done", 32'(done_seen - d0), 32'd0);

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0), W'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
